stack_mp: RTL and testbench
===========================

// Module: stack_mp
// PURPOSE
//  Multi-port LIFO: up to PUSH writes and POP reads per cycle, occupancy count and error pulse.
//  Next-generation parametrised stack for wide front-end structures (return-address stack, free lists).
//  Pop and push in one cycle resolve as pop-then-push. rd always presents the top POP entries.
// PARAMETERS
//  DATA   32  entry width in bits
//  DEPTH  16  number of entries; must be >= max(PUSH,POP); must be a power of two when STACK_WRAP_EN
//  PUSH    2  push lanes per cycle
//  POP     2  pop lanes per cycle
//  CNT    $clog2(DEPTH+1)  count width (derived; do not override)
// PORTS
//  clk    in   1           clock; all state updates on rising edge
//  reset  in   1           synchronous, active-high reset
//  push   in   PUSH        push lane enables
//  wd     in   PUSH*DATA   push data, packed [PUSH-1:0][DATA-1:0]
//  pop    in   POP         pop lane enables
//  rd     out  POP*DATA    rd[0]=top, rd[1]=top-1, ... (combinational from storage)
//  v      out  POP         v[i]=1 iff count > i
//  count  out  CNT         current occupancy, 0..DEPTH
//  busy   out  1           count > DEPTH-PUSH (a full-width push cannot be guaranteed)
//  err    out  1           registered 1-cycle pulse: overflow reject or underflow in the previous cycle
// BEHAVIOUR
//  - Reset: count=0, top pointer=0, err=0; hence v=0, busy=0 (DEPTH>=PUSH), rd=0. Storage not cleared.
//  - rd[i] is forced to 0 when v[i]=0; never expose stale storage.
//  - Lane decode: npush = run of contiguous 1s from push[0]; higher bits after the first 0 are ignored.
//    npop is decoded from pop the same way.
//  - Pop: npop_eff = min(npop, count). Underflow (npop > count) sets err next cycle; entries that exist are removed.
//  - Push base = count - npop_eff. wd[i] is written at base+i, so wd[npush-1] becomes the new top.
//  - Next count = count - npop_eff + npush (if accepted). rd is valid in the same cycle as pop.
//    The popped data is the value rd shows in that cycle.
//  - Same-cycle pop+push: a popped entry's slot can be rewritten in that cycle with no conflict.
//    Example: count=3, pop=2'b01, push=2'b01 -> top replaced, count stays 3.
//  - Overflow (no macro): if base+npush > DEPTH, the whole push group is rejected. Pops still apply, err=1 next cycle.
//    No partial push.
//  - No pipeline/latency: state visible on outputs the cycle after the edge; err lags its cause by 1 cycle.
//  - reset has priority over push/pop in the same cycle; any in-flight operation is discarded.
//  - Arithmetic: all pointer/count maths in CNT+1 bits, no silent truncation.
// CONFIGURATION
//  STACK_WRAP_EN defined: storage is a circular buffer (top pointer mod DEPTH).
//   - Pushes are always accepted; the oldest entries are silently overwritten.
//   - count saturates at DEPTH. Overflow never raises err; underflow still does.
//   - busy is tied 0.
//   - Popping after a wrap returns only the surviving newest DEPTH entries, then v drops.
//  STACK_WRAP_EN undefined: reject-on-overflow behaviour as above. DEPTH may be any value >= max(PUSH,POP).
// TESTING (DATA=32, DEPTH=4, PUSH=2, POP=2)
//  1. Reset then idle -> count=0, v=2'b00, rd=0, busy=0, err=0.
//  2. push=2'b11, wd={B,A}=32'hdeadbef0/32'hdeadbeef -> next cycle count=2, rd[0]=..f0, rd[1]=..ef, v=2'b11.
//     Then pop=2'b01 -> count=1, rd[0]=..ef.
//  3. count=3 [C,B,A top=C]; pop=2'b01 + push=2'b01 wd=D -> count=3, rd[0]=D, rd[1]=B.
//  4. count=3; push=2'b11 (no macro) -> rejected, count=3, err=1 for one cycle; busy=1 throughout.
//     With STACK_WRAP_EN -> count=4, rd[0]/rd[1] are the new data, err=0.
//  5. count=1; pop=2'b11 -> count=0, err=1 next cycle, v=0. Push=2'b10 (non-contiguous) -> ignored, count=0.
//  6. reset asserted in the same cycle as push=2'b11 -> count=0 after the edge, err=0.

Source files
------------

// File: rtl/stack_mp.sv
// ---------------------------------------------------------------------------
// stack_mp -- multi-port LIFO
//
// Accepts up to PUSH writes and POP reads per cycle. A pop and a push in the
// same cycle resolve as pop-then-push. The top POP entries are always
// presented on rd. The module reports occupancy and raises a one-cycle error
// pulse.
//
// Parameters
//   DATA   entry width in bits
//   DEPTH  number of entries; must be >= max(PUSH, POP), and a power of two
//          when STACK_WRAP_EN is defined
//   PUSH   push lanes per cycle
//   POP    pop lanes per cycle
//   CNT    count width, derived as $clog2(DEPTH+1); do not override
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   push   in   [PUSH]        push lane enables (contiguous run from bit 0)
//   wd     in   [PUSH][DATA]  push data; wd[npush-1] becomes the new top
//   pop    in   [POP]         pop lane enables (contiguous run from bit 0)
//   rd     out  [POP][DATA]   rd[0]=top, rd[1]=top-1 ...; 0 when not valid
//   v      out  [POP]         v[i]=1 iff count > i
//   count  out  [CNT]         current occupancy, 0..DEPTH
//   busy   out  count > DEPTH-PUSH
//   err    out  registered pulse: overflow reject or underflow last cycle
//
// Configuration macro: STACK_WRAP_EN
//   defined   : circular storage. Pushes are never rejected, the oldest
//               entries are overwritten, count saturates at DEPTH, and busy
//               is tied to 0. Underflow still raises err.
//   undefined : a push group that does not fit is rejected as a whole.
// ---------------------------------------------------------------------------
module stack_mp #(
    parameter int unsigned DATA  = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PUSH  = 2,
    parameter int unsigned POP   = 2,
    parameter int unsigned CNT   = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PUSH-1:0]            push,
    input  logic [PUSH-1:0][DATA-1:0]  wd,
    input  logic [POP-1:0]             pop,
    output logic [POP-1:0][DATA-1:0]   rd,
    output logic [POP-1:0]             v,
    output logic [CNT-1:0]             count,
    output logic                       busy,
    output logic                       err
);

    // All pointer and count arithmetic uses one spare bit, so intermediate
    // sums such as base+npush cannot overflow.
    localparam int unsigned W  = CNT + 1;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [W-1:0] DEPTH_W = W'(DEPTH);

    // Storage is deliberately not reset.
    logic [DATA-1:0] r_mem [DEPTH];
    logic [CNT-1:0]  r_count;
    logic [CNT-1:0]  r_ptr;      // next free slot (mod DEPTH when wrapping)
    logic            r_err;

    logic [W-1:0]    w_count;
    logic [W-1:0]    w_ptr;
    logic [W-1:0]    w_npush;
    logic [W-1:0]    w_npop;
    logic            w_push_run;
    logic            w_pop_run;
    logic            w_underflow;
    logic [W-1:0]    w_npop_eff;
    logic [W-1:0]    w_base;
    logic [W-1:0]    w_ptr_base;
    logic [W-1:0]    w_sum;
    logic            w_accept;
    logic            w_err_next;
    logic [W-1:0]    w_next_count;
    logic [W-1:0]    w_next_ptr;
    logic [AW-1:0]   w_wr_addr [PUSH];
    logic [AW-1:0]   w_rd_addr [POP];

    assign w_count = W'(r_count);
    assign w_ptr   = W'(r_ptr);

    // Lane decode: length of the run of 1s starting at bit 0. Any lane
    // after the first 0 is ignored.
    always_comb begin
        w_npush    = '0;
        w_push_run = 1'b1;
        for (int unsigned i = 0; i < PUSH; i++) begin
            if (w_push_run && push[i]) begin
                w_npush = w_npush + W'(1);
            end else begin
                w_push_run = 1'b0;
            end
        end
    end

    always_comb begin
        w_npop    = '0;
        w_pop_run = 1'b1;
        for (int unsigned i = 0; i < POP; i++) begin
            if (w_pop_run && pop[i]) begin
                w_npop = w_npop + W'(1);
            end else begin
                w_pop_run = 1'b0;
            end
        end
    end

    // Pop first: remove only the entries that exist. The push group then
    // lands on top of what remains.
    always_comb begin
        w_underflow = (w_npop > w_count);
        w_npop_eff  = w_underflow ? w_count : w_npop;
        w_base      = w_count - w_npop_eff;
        w_ptr_base  = w_ptr - w_npop_eff;
        w_sum       = w_base + w_npush;
    end

`ifdef STACK_WRAP_EN
    localparam logic [W-1:0] PTR_MASK = W'(DEPTH - 1);

    // Circular storage: accept every push, keep the newest DEPTH entries.
    always_comb begin
        w_accept     = 1'b1;
        w_err_next   = w_underflow;
        w_next_count = (w_sum > DEPTH_W) ? DEPTH_W : w_sum;
        w_next_ptr   = (w_ptr_base + w_npush) & PTR_MASK;
    end

    assign busy = 1'b0;
`else
    logic w_overflow;

    // A group that does not fit is dropped whole. The pops still happen.
    always_comb begin
        w_overflow   = (w_sum > DEPTH_W);
        w_accept     = !w_overflow;
        w_err_next   = w_underflow | w_overflow;
        w_next_count = w_accept ? w_sum : w_base;
        w_next_ptr   = w_accept ? (w_ptr_base + w_npush) : w_ptr_base;
    end

    assign busy = (w_count > (DEPTH_W - W'(PUSH)));
`endif

    // Truncating to AW bits performs the mod-DEPTH wrap for a power-of-two
    // DEPTH. Without wrap, the slot is always in range whenever it is used.
    always_comb begin
        for (int unsigned i = 0; i < PUSH; i++) begin
            w_wr_addr[i] = AW'(w_ptr_base + W'(i));
        end
        for (int unsigned i = 0; i < POP; i++) begin
            w_rd_addr[i] = AW'(w_ptr - W'(1) - W'(i));
        end
    end

    // Storage write. A slot freed by a pop this cycle may be rewritten here.
    // Lanes write distinct slots because DEPTH >= PUSH.
    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            for (int unsigned i = 0; i < PUSH; i++) begin
                if (W'(i) < w_npush) begin
                    r_mem[w_wr_addr[i]] <= wd[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_ptr   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_count <= CNT'(w_next_count);
            r_ptr   <= CNT'(w_next_ptr);
            r_err   <= w_err_next;
        end
    end

    // The read side is combinational from storage. Invalid lanes are
    // zeroed so stale entries never leak out.
    always_comb begin
        for (int unsigned i = 0; i < POP; i++) begin
            v[i]  = (w_count > W'(i));
            rd[i] = v[i] ? r_mem[w_rd_addr[i]] : '0;
        end
    end

    assign count = r_count;
    assign err   = r_err;

endmodule

// File: tb/tb_stack_mp.sv
module tb_stack_mp;

    localparam int unsigned DATA  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PUSH  = 2;
    localparam int unsigned POP   = 2;
    localparam int unsigned CNT   = 3;

`ifdef STACK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       reset;
    logic [PUSH-1:0]            push;
    logic [PUSH-1:0][DATA-1:0]  wd;
    logic [POP-1:0]             pop;
    logic [POP-1:0][DATA-1:0]   rd;
    logic [POP-1:0]             v;
    logic [CNT-1:0]             count;
    logic                       busy;
    logic                       err;

    stack_mp #(
        .DATA (DATA),
        .DEPTH(DEPTH),
        .PUSH (PUSH),
        .POP  (POP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .wd   (wd),
        .pop  (pop),
        .rd   (rd),
        .v    (v),
        .count(count),
        .busy (busy),
        .err  (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [2:0]    cnt;
        bit [1:0]    v;
        logic [31:0] rd0;
        logic [31:0] rd1;
        bit          busy;
        bit          err;
    } exp_t;

    typedef struct {
        bit          rst;
        bit [1:0]    push;
        bit [1:0]    pop;
        logic [31:0] wd0;
        logic [31:0] wd1;
        exp_t        e;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[$];
    logic [31:0] mq[$];
    int          checks   = 0;
    int          failures = 0;

    function automatic exp_t ex(int c, bit [1:0] vv, logic [31:0] r0, logic [31:0] r1,
                                bit b, bit e);
        exp_t x;
        x.cnt  = 3'(c);
        x.v    = vv;
        x.rd0  = r0;
        x.rd1  = r1;
        x.busy = b;
        x.err  = e;
        return x;
    endfunction

    function automatic vec_t vc(bit rst, bit [1:0] pu, bit [1:0] po,
                                logic [31:0] a, logic [31:0] b, exp_t e);
        vec_t x;
        x.rst  = rst;
        x.push = pu;
        x.pop  = po;
        x.wd0  = a;
        x.wd1  = b;
        x.e    = e;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic compare(string tag);
        exp_t e;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, " count"}, 32'(count), 32'(e.cnt));
        chk({tag, " v"},     32'(v),     32'(e.v));
        chk({tag, " rd0"},   rd[0],      e.rd0);
        chk({tag, " rd1"},   rd[1],      e.rd1);
        chk({tag, " busy"},  32'(busy),  32'(e.busy));
        chk({tag, " err"},   32'(err),   32'(e.err));
    endtask

    task automatic apply(bit rst, bit [1:0] pu, bit [1:0] po,
                         logic [31:0] a, logic [31:0] b, exp_t e, string tag);
        reset = rst;
        push  = pu;
        pop   = po;
        wd[0] = a;
        wd[1] = b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    function automatic int lanes(bit [1:0] x);
        return x[0] ? (x[1] ? 2 : 1) : 0;
    endfunction

    // Reference model as a plain queue, newest entry at the back.
    function automatic exp_t model_step(bit rst, bit [1:0] pu, bit [1:0] po,
                                        logic [31:0] a, logic [31:0] b);
        exp_t e;
        int   np;
        int   nu;
        bit   under;
        bit   over;
        under = 1'b0;
        over  = 1'b0;
        if (rst) begin
            mq.delete();
        end else begin
            np    = lanes(po);
            nu    = lanes(pu);
            under = (np > mq.size());
            for (int k = 0; k < np; k++) begin
                if (mq.size() > 0) void'(mq.pop_back());
            end
            if (!WRAP && (mq.size() + nu > DEPTH)) begin
                over = 1'b1;
            end else begin
                if (nu > 0) mq.push_back(a);
                if (nu > 1) mq.push_back(b);
                while (mq.size() > DEPTH) void'(mq.pop_front());
            end
        end
        e.cnt  = 3'(mq.size());
        e.v    = {mq.size() > 1, mq.size() > 0};
        e.rd0  = (mq.size() > 0) ? mq[mq.size() - 1] : 32'h0;
        e.rd1  = (mq.size() > 1) ? mq[mq.size() - 2] : 32'h0;
        e.busy = !WRAP && (mq.size() > DEPTH - PUSH);
        e.err  = under || over;
        return e;
    endfunction

    initial begin
        logic [31:0] A, B, B2, C, D, E, F, G, X, Y, Z, Wv, V, P, Q, J;
        bit          nb;
        A  = 32'hdeadbeef; B  = 32'hdeadbef0;
        B2 = 32'h11110002; C  = 32'h11110003; D  = 32'h11110004;
        E  = 32'h11110005; F  = 32'h11110006; G  = 32'h11110007;
        X  = 32'h11110008; Y  = 32'h11110009; Z  = 32'h1111000a;
        Wv = 32'h1111000b; V  = 32'h1111000c; P  = 32'h1111000d;
        Q  = 32'h1111000e; J  = 32'hffffffff;
        nb = !WRAP;

        reset = 1'b1;
        push  = '0;
        pop   = '0;
        wd    = '0;

        tbl.push_back(vc(1, 2'b00, 2'b00, 0, 0, ex(0, 2'b00, 0, 0, 0, 0)));
        tbl.push_back(vc(0, 2'b00, 2'b00, 0, 0, ex(0, 2'b00, 0, 0, 0, 0)));
        tbl.push_back(vc(0, 2'b11, 2'b00, A, B, ex(2, 2'b11, B, A, 0, 0)));
        tbl.push_back(vc(0, 2'b00, 2'b01, J, J, ex(1, 2'b01, A, 0, 0, 0)));
        tbl.push_back(vc(0, 2'b11, 2'b00, B2, C, ex(3, 2'b11, C, B2, nb, 0)));
        tbl.push_back(vc(0, 2'b01, 2'b01, D, J, ex(3, 2'b11, D, B2, nb, 0)));
        tbl.push_back(vc(0, 2'b11, 2'b00, E, F,
                         WRAP ? ex(4, 2'b11, F, E, 0, 0) : ex(3, 2'b11, D, B2, 1, 1)));
        tbl.push_back(vc(0, 2'b00, 2'b00, J, J,
                         WRAP ? ex(4, 2'b11, F, E, 0, 0) : ex(3, 2'b11, D, B2, 1, 0)));
        tbl.push_back(vc(1, 2'b11, 2'b00, J, J, ex(0, 2'b00, 0, 0, 0, 0)));
        tbl.push_back(vc(0, 2'b01, 2'b00, G, J, ex(1, 2'b01, G, 0, 0, 0)));
        tbl.push_back(vc(0, 2'b00, 2'b11, J, J, ex(0, 2'b00, 0, 0, 0, 1)));
        tbl.push_back(vc(0, 2'b00, 2'b00, J, J, ex(0, 2'b00, 0, 0, 0, 0)));
        tbl.push_back(vc(0, 2'b10, 2'b00, J, J, ex(0, 2'b00, 0, 0, 0, 0)));
        tbl.push_back(vc(0, 2'b00, 2'b10, J, J, ex(0, 2'b00, 0, 0, 0, 0)));
        tbl.push_back(vc(0, 2'b00, 2'b01, J, J, ex(0, 2'b00, 0, 0, 0, 1)));
        tbl.push_back(vc(0, 2'b11, 2'b00, X, Y, ex(2, 2'b11, Y, X, 0, 0)));
        tbl.push_back(vc(0, 2'b01, 2'b00, Z, J, ex(3, 2'b11, Z, Y, nb, 0)));
        tbl.push_back(vc(0, 2'b01, 2'b00, Wv, J, ex(4, 2'b11, Wv, Z, nb, 0)));
        tbl.push_back(vc(0, 2'b01, 2'b00, V, J,
                         WRAP ? ex(4, 2'b11, V, Wv, 0, 0) : ex(4, 2'b11, Wv, Z, 1, 1)));
        tbl.push_back(vc(0, 2'b11, 2'b11, P, Q, ex(4, 2'b11, Q, P, nb, 0)));
        tbl.push_back(vc(0, 2'b00, 2'b11, J, J,
                         WRAP ? ex(2, 2'b11, Z, Y, 0, 0) : ex(2, 2'b11, Y, X, 0, 0)));
        tbl.push_back(vc(0, 2'b00, 2'b11, J, J, ex(0, 2'b00, 0, 0, 0, 0)));
        tbl.push_back(vc(0, 2'b00, 2'b00, J, J, ex(0, 2'b00, 0, 0, 0, 0)));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst, tbl[i].push, tbl[i].pop, tbl[i].wd0, tbl[i].wd1,
                  tbl[i].e, $sformatf("vec%0d", i));
        end

        // Random traffic against the queue model. The DUT and the model
        // are both empty here, following the last table row.
        mq.delete();
        for (int n = 0; n < 300; n++) begin
            bit          rr;
            bit [1:0]    pu;
            bit [1:0]    po;
            logic [31:0] a;
            logic [31:0] b;
            exp_t        e;
            rr = ($urandom_range(0, 39) == 0);
            pu = 2'($urandom_range(0, 3));
            po = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            e  = model_step(rr, pu, po, a, b);
            apply(rr, pu, po, a, b, e, $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
